// File: rtl/imem_responder.sv
// Multi-cycle instruction-memory responder: fixed-latency reads/writes with done pulse and stall.
// Optional one-entry next-word prefetch buffer enabled by defining IMEM_PREFETCH_EN.
module imem_responder #(
    parameter int          AW      = 8,
    parameter int          LATENCY = 4,
    parameter logic [15:0] NOP     = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [15:0] data_in,
    input  logic        flush,
    output logic [15:0] data_out,
    output logic        done,
    output logic        stall,
    output logic        err
);
    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
    localparam bit SHORT = (LATENCY == 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   idx_q;
    logic            mis_q;
    logic            wr_q;
    logic [15:0]     wdata_q;
    logic [15:0]     mem [2**AW];
    logic [15:0]     rdata;
    logic            accept;
    logic            commit;
    logic            hit;
    logic            addr_unused;

    // Upper address bits are dropped so accesses wrap.
    assign addr_unused = ^addr[15:AW+1];

    assign accept = (state == IDLE) && (rd || wr);
    // A write cancelled by flush still lands; reset drops it.
    assign commit = wr_q && !mis_q && !rst &&
                    ((state == RESP) || ((state == WAIT) && flush));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (rd || wr) state_nxt = (hit || SHORT) ? RESP : WAIT;
            WAIT: begin
                if (flush)                 state_nxt = IDLE;
                else if (cnt == CW'(1))    state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            mis_q   <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                idx_q   <= addr[AW:1];
                mis_q   <= addr[0];
                wr_q    <= wr;
                wdata_q <= data_in;
                cnt     <= CW'(LATENCY - 1);
            end else if (state == WAIT) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit) mem[idx_q] <= wdata_q;
    end

    assign done     = (state == RESP);
    assign err      = done && mis_q;
    assign stall    = (rd || wr) && !done;
    assign data_out = (done && !wr_q && !mis_q) ? rdata : NOP;

`ifdef IMEM_PREFETCH_EN
    logic            pf_valid;
    logic            pf_busy;
    logic [AW-1:0]   pf_tag;
    logic [15:0]     pf_data;
    logic [CW-1:0]   pf_cnt;
    logic            hit_q;
    logic            rd_done;

    assign hit     = rd && !wr && !addr[0] && pf_valid && (addr[AW:1] == pf_tag);
    assign rd_done = (state == RESP) && !wr_q && !mis_q;
    assign rdata   = hit_q ? pf_data : mem[idx_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            pf_valid <= 1'b0;
            pf_busy  <= 1'b0;
            pf_tag   <= '0;
            pf_data  <= '0;
            pf_cnt   <= '0;
            hit_q    <= 1'b0;
        end else begin
            if (accept) hit_q <= hit;
            // Every completed read refills the buffer with the following word.
            if (rd_done) begin
                pf_busy  <= 1'b1;
                pf_valid <= 1'b0;
                pf_tag   <= idx_q + AW'(1);
                pf_cnt   <= CW'(LATENCY);
            end else if (flush) begin
                pf_valid <= 1'b0;
                pf_busy  <= 1'b0;
            end else if (accept && !hit) begin
                pf_busy <= 1'b0;
            end else if (pf_busy) begin
                if (pf_cnt == CW'(1)) begin
                    pf_busy  <= 1'b0;
                    pf_valid <= 1'b1;
                    pf_data  <= mem[pf_tag];
                end else begin
                    pf_cnt <= pf_cnt - CW'(1);
                end
            end
            if (commit && (idx_q == pf_tag)) pf_valid <= 1'b0;
        end
    end
`else
    assign hit   = 1'b0;
    assign rdata = mem[idx_q];
`endif

endmodule
